ex_alu_stage: RTL and testbench

Execute stage of the pipelined MIPS core. It consumes the 4-bit ALU control code from the ALU control decoder and the operands from the ID/EX boundary, then computes the ALU result, zero flag and overflow flag. The result is registered into the EX/MEM output together with the pass-through control fields. A two-entry skid buffer (output register plus skid register) gives a fully registered valid/ready handshake, so MEM-stage stalls never create a combinational path back into ID.

---
 rtl/ex_alu_stage_if.sv | 43 ++++
 rtl/ex_alu_stage.sv | 147 ++++++++++++++
 tb/tb_ex_alu_stage.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_alu_stage_if.sv
// Handshake and operand bundle between ID/EX, the execute stage and EX/MEM.
// The stage connects through the slave modport; the upstream/downstream side uses master.
interface ex_alu_stage_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_cntrl;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [4:0]       shamt;
  logic [4:0]       rd_addr;
  logic             reg_write;
  logic             mem_read;
  logic             mem_write;
  logic [WIDTH-1:0] store_data;
  logic             flush;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_ovf;
  logic             out_illegal;
  logic [4:0]       out_rd_addr;
  logic             out_reg_write;
  logic             out_mem_read;
  logic             out_mem_write;
  logic [WIDTH-1:0] out_store_data;

  modport master (
    output in_valid, alu_cntrl, src_a, src_b, shamt, rd_addr, reg_write, mem_read, mem_write,
    output store_data, flush, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_ovf, out_illegal, out_rd_addr,
    input  out_reg_write, out_mem_read, out_mem_write, out_store_data
  );

  modport slave (
    input  in_valid, alu_cntrl, src_a, src_b, shamt, rd_addr, reg_write, mem_read, mem_write,
    input  store_data, flush, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_ovf, out_illegal, out_rd_addr,
    output out_reg_write, out_mem_read, out_mem_write, out_store_data
  );
endinterface

// File: rtl/ex_alu_stage.sv
// MIPS execute stage: combinational ALU feeding a two-entry skid buffer
// (output register + skid register) with a registered in_ready.
module ex_alu_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  ex_alu_stage_if.slave  bus_io
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             ovf;
    logic             illegal;
    logic [4:0]       rd_addr;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic [WIDTH-1:0] store_data;
  } entry_t;

  // State is just {out_valid, skid_valid}; 01 cannot occur.
  localparam logic [1:0] StEmpty = 2'b00;
  localparam logic [1:0] StOne   = 2'b10;
  localparam logic [1:0] StFull  = 2'b11;

  logic [WIDTH-1:0] a, b, sum, diff, res;
  logic             ovf, illegal;
  entry_t           new_entry;

  assign a    = bus_io.src_a;
  assign b    = bus_io.src_b;
  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    res     = '0;
    ovf     = 1'b0;
    illegal = 1'b0;
    case (bus_io.alu_cntrl)
      4'b0000: res = b << bus_io.shamt;
      4'b0010: res = b >> bus_io.shamt;
      4'b0001: res = $signed(b) >>> bus_io.shamt;
      4'b1000: begin
        res = sum;
        ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'b1001: begin
        res = diff;
        ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      4'b1100: res = a & b;
      4'b1101: res = a | b;
      4'b1111: res = a ^ b;
      4'b1110: res = ~(a | b);
      4'b0101: res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    new_entry.result     = res;
    new_entry.zero       = (res == '0);
    new_entry.ovf        = ovf;
    new_entry.illegal    = illegal;
    new_entry.rd_addr    = bus_io.rd_addr;
    new_entry.reg_write  = bus_io.reg_write;
    new_entry.mem_read   = bus_io.mem_read;
    new_entry.mem_write  = bus_io.mem_write;
    new_entry.store_data = bus_io.store_data;
  end

  entry_t out_q, out_d, skid_q, skid_d;
  logic   out_valid_q, out_valid_d, skid_valid_q, skid_valid_d, in_ready_q, in_ready_d;
  logic   fire, drain;

  assign fire  = bus_io.in_valid & in_ready_q;
  assign drain = out_valid_q & bus_io.out_ready;

  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (bus_io.flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      case ({out_valid_q, skid_valid_q})
        StEmpty: begin
          if (fire) begin
            out_d       = new_entry;
            out_valid_d = 1'b1;
          end
        end
        StOne: begin
          if (fire && drain) begin
            out_d = new_entry;
          end else if (fire) begin
            skid_d       = new_entry;
            skid_valid_d = 1'b1;
          end else if (drain) begin
            out_valid_d = 1'b0;
          end
        end
        StFull: begin
          if (drain) begin
            out_d        = skid_q;
            skid_valid_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
    in_ready_d = !(out_valid_d && skid_valid_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign bus_io.in_ready       = in_ready_q;
  assign bus_io.out_valid      = out_valid_q;
  assign bus_io.out_result     = out_q.result;
  assign bus_io.out_zero       = out_q.zero;
  assign bus_io.out_ovf        = out_q.ovf;
  assign bus_io.out_illegal    = out_q.illegal;
  assign bus_io.out_rd_addr    = out_q.rd_addr;
  assign bus_io.out_reg_write  = out_q.reg_write;
  assign bus_io.out_mem_read   = out_q.mem_read;
  assign bus_io.out_mem_write  = out_q.mem_write;
  assign bus_io.out_store_data = out_q.store_data;

endmodule

// File: tb/tb_ex_alu_stage.sv
// Bench for ex_alu_stage: directed vector table, hand-written buffer sequences and a
// random stream checked against a queue-based reference model.
module tb_ex_alu_stage;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  ex_alu_stage_if #(.WIDTH(32)) bus ();

  ex_alu_stage #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [31:0] sd;
  } in_t;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        ovf;
    logic        illegal;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [31:0] sd;
  } exp_t;

  typedef struct {
    in_t         in;
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    logic        ill;
  } vec_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic from the operation rules.
  function automatic exp_t model(input in_t x);
    exp_t   e;
    int     sa, sb;
    longint s;
    sa = x.a;
    sb = x.b;
    e = '0;
    case (x.code)
      4'b0000: e.result = x.b << x.shamt;
      4'b0010: e.result = x.b >> x.shamt;
      4'b0001: e.result = sb >>> x.shamt;
      4'b1000: begin
        s = longint'(sa) + longint'(sb);
        e.result = s[31:0];
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b1001: begin
        s = longint'(sa) - longint'(sb);
        e.result = s[31:0];
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b1100: e.result = x.a & x.b;
      4'b1101: e.result = x.a | x.b;
      4'b1111: e.result = x.a ^ x.b;
      4'b1110: e.result = ~(x.a | x.b);
      4'b0101: e.result = (sa < sb) ? 32'd1 : 32'd0;
      default: e.illegal = 1'b1;
    endcase
    e.zero = (e.result == 32'd0);
    e.rd = x.rd;
    e.rw = x.rw;
    e.mr = x.mr;
    e.mw = x.mw;
    e.sd = x.sd;
    return e;
  endfunction

  function automatic exp_t get_out();
    exp_t e;
    e.result  = bus.out_result;
    e.zero    = bus.out_zero;
    e.ovf     = bus.out_ovf;
    e.illegal = bus.out_illegal;
    e.rd      = bus.out_rd_addr;
    e.rw      = bus.out_reg_write;
    e.mr      = bus.out_mem_read;
    e.mw      = bus.out_mem_write;
    e.sd      = bus.out_store_data;
    return e;
  endfunction

  function automatic in_t rand_in();
    in_t x;
    x.code  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b1000;
    x.a     = $urandom;
    x.b     = ($urandom_range(0, 3) == 0) ? x.a : $urandom;
    x.shamt = 5'($urandom_range(0, 31));
    x.rd    = 5'($urandom_range(0, 31));
    x.rw    = 1'($urandom_range(0, 1));
    x.mr    = 1'($urandom_range(0, 1));
    x.mw    = 1'($urandom_range(0, 1));
    x.sd    = $urandom;
    return x;
  endfunction

  task automatic drive(input in_t x, input logic valid);
    bus.in_valid   = valid;
    bus.alu_cntrl  = x.code;
    bus.src_a      = x.a;
    bus.src_b      = x.b;
    bus.shamt      = x.shamt;
    bus.rd_addr    = x.rd;
    bus.reg_write  = x.rw;
    bus.mem_read   = x.mr;
    bus.mem_write  = x.mw;
    bus.store_data = x.sd;
  endtask

  function automatic in_t mk(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] sh, input logic [4:0] rd, input logic rw);
    in_t x;
    x = '0;
    x.code = c; x.a = a; x.b = b; x.shamt = sh; x.rd = rd; x.rw = rw;
    x.sd = a ^ 32'h5A5A_0000;
    return x;
  endfunction

  // Load two entries with out_ready low so the stage ends up FULL.
  task automatic fill_full(input in_t x0, input in_t x1);
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(x0, 1'b1);
    @(negedge clk);
    drive(x1, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("fill_in_ready", 128'(bus.in_ready), 128'(1'b0));
  endtask

  vec_t vecs[11];
  in_t  qa, qb, qc, xin;
  exp_t q[$];
  logic fire, drain, do_flush;

  initial begin
    vecs[0]  = '{mk(4'b1000, 32'h7FFF_FFFF, 32'h1, 0, 1, 1), 32'h8000_0000, 0, 1, 0};
    vecs[1]  = '{mk(4'b1001, 32'd5, 32'd5, 0, 2, 1), 32'h0, 1, 0, 0};
    vecs[2]  = '{mk(4'b0001, 32'h0, 32'h8000_0000, 4, 3, 1), 32'hF800_0000, 0, 0, 0};
    vecs[3]  = '{mk(4'b0010, 32'h0, 32'h8000_0000, 4, 4, 0), 32'h0800_0000, 0, 0, 0};
    vecs[4]  = '{mk(4'b0101, 32'hFFFF_FFFF, 32'h1, 0, 5, 1), 32'h1, 0, 0, 0};
    vecs[5]  = '{mk(4'b1110, 32'h0, 32'h0, 0, 6, 1), 32'hFFFF_FFFF, 0, 0, 0};
    vecs[6]  = '{mk(4'b0111, 32'h1234, 32'h5678, 0, 9, 1), 32'h0, 1, 0, 1};
    vecs[7]  = '{mk(4'b0000, 32'h0, 32'h1, 31, 7, 1), 32'h8000_0000, 0, 0, 0};
    vecs[8]  = '{mk(4'b1100, 32'hF0F0_00FF, 32'h0FF0_0F0F, 0, 8, 1), 32'h00F0_000F, 0, 0, 0};
    vecs[9]  = '{mk(4'b1111, 32'hF0F0_00FF, 32'h0FF0_0F0F, 0, 10, 1), 32'hFF00_0FF0, 0, 0, 0};
    vecs[10] = '{mk(4'b1001, 32'h8000_0000, 32'h1, 0, 11, 1), 32'h7FFF_FFFF, 0, 1, 0};

    rst = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    drive('0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("reset_out_valid", 128'(bus.out_valid), 128'(1'b0));
    check("reset_in_ready", 128'(bus.in_ready), 128'(1'b1));
    check("reset_out_fields", 128'(get_out()), 128'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed table, one accept per cycle with out_ready high.
    foreach (vecs[i]) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      drive(vecs[i].in, 1'b1);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_valid", i), 128'(bus.out_valid), 128'(1'b1));
      check($sformatf("vec%0d_result", i), 128'(bus.out_result), 128'(vecs[i].res));
      check($sformatf("vec%0d_flags", i), 128'({bus.out_zero, bus.out_ovf, bus.out_illegal}),
            128'({vecs[i].zero, vecs[i].ovf, vecs[i].ill}));
      check($sformatf("vec%0d_rd", i), 128'({bus.out_rd_addr, bus.out_reg_write}),
            128'({vecs[i].in.rd, vecs[i].in.rw}));
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("table_drained", 128'(bus.out_valid), 128'(1'b0));

    // Back-to-back A, B, C with out_ready low after A.
    qa = mk(4'b1000, 32'd10, 32'd1, 0, 1, 1);
    qb = mk(4'b1000, 32'd20, 32'd2, 0, 2, 1);
    qc = mk(4'b1000, 32'd30, 32'd3, 0, 3, 1);
    fill_full(qa, qb);
    check("b2b_hold_a", 128'(get_out()), 128'(model(qa)));
    drive(qc, 1'b1);
    @(negedge clk);
    check("b2b_c_held_ready", 128'(bus.in_ready), 128'(1'b0));
    check("b2b_still_a", 128'(get_out()), 128'(model(qa)));
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("b2b_out_b", 128'(get_out()), 128'(model(qb)));
    check("b2b_ready_back", 128'(bus.in_ready), 128'(1'b1));
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("b2b_out_c", 128'(get_out()), 128'(model(qc)));
    check("b2b_c_valid", 128'(bus.out_valid), 128'(1'b1));
    @(negedge clk);
    check("b2b_empty", 128'(bus.out_valid), 128'(1'b0));

    // Flush while FULL with an input presented.
    fill_full(qa, qb);
    drive(qc, 1'b1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    check("flush_out_valid", 128'(bus.out_valid), 128'(1'b0));
    check("flush_in_ready", 128'(bus.in_ready), 128'(1'b1));
    @(negedge clk);
    check("flush_no_emit", 128'(bus.out_valid), 128'(1'b0));

    // Reset while FULL acts without a clock edge.
    fill_full(qa, qb);
    #2 rst = 1'b1;
    #1;
    check("rst_full_out_valid", 128'(bus.out_valid), 128'(1'b0));
    check("rst_full_in_ready", 128'(bus.in_ready), 128'(1'b1));
    check("rst_full_result", 128'(bus.out_result), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    drive(qc, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("rst_first_accept", 128'(get_out()), 128'(model(qc)));
    check("rst_first_valid", 128'(bus.out_valid), 128'(1'b1));

    // Empty the stage so the scoreboard starts in sync.
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;

    // Random stream against a FIFO model of depth 2.
    for (int n = 0; n < 2000; n++) begin
      check("rnd_out_valid", 128'(bus.out_valid), 128'(q.size() > 0));
      check("rnd_in_ready", 128'(bus.in_ready), 128'(q.size() < 2));
      if (bus.out_valid && q.size() > 0) check("rnd_entry", 128'(get_out()), 128'(q[0]));
      xin = rand_in();
      do_flush = ($urandom_range(0, 40) == 0);
      drive(xin, 1'($urandom_range(0, 2) != 0));
      bus.out_ready = 1'($urandom_range(0, 2) != 0);
      bus.flush = do_flush;
      fire  = bus.in_valid && bus.in_ready;
      drain = bus.out_valid && bus.out_ready;
      if (do_flush) begin
        q.delete();
      end else begin
        if (drain && q.size() > 0) void'(q.pop_front());
        if (fire) q.push_back(model(xin));
      end
      @(negedge clk);
    end
    bus.flush = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
